// File: rtl/iob_pcie_tx_arb.sv
// iob_pcie_tx_arb: two-requester round-robin arbiter in front of a PCIe TX channel.
// A granted requester keeps the channel for a whole transaction: request/ack
// handshake, then (len+1)/2 64-bit beats, then a one-cycle DONE pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; arbitrate among REQ bits
// REQ    | winner latched; PCIE_CHNL_TX up (unless len==0), wait for ACK
// DATA   | stream beats from the granted requester, count down to zero
// DONE   | one-cycle DONE pulse to the winner, grant released
module iob_pcie_tx_arb #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [1:0]                    REQ,
  input  logic [2*DATA_W-1:0]           REQ_LEN,
  input  logic [1:0]                    REQ_LAST,
  input  logic [2*C_PCI_DATA_WIDTH-1:0] REQ_DATA,
  input  logic [1:0]                    REQ_DATA_VALID,
  output logic [1:0]                    REQ_DATA_REN,
  output logic [1:0]                    GNT,
  output logic [1:0]                    DONE,
  output logic                          BUSY,
  output logic                          PCIE_CHNL_TX,
  input  logic                          PCIE_CHNL_TX_ACK,
  output logic                          PCIE_CHNL_TX_LAST,
  output logic [DATA_W-1:0]             PCIE_CHNL_TX_LEN,
  output logic [DATA_W-2:0]             PCIE_CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]   PCIE_CHNL_TX_DATA,
  output logic                          PCIE_CHNL_TX_DATA_VALID,
  input  logic                          PCIE_CHNL_TX_DATA_REN
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ptr;
  logic                  r_idx;
  logic                  r_last;
  logic [DATA_W-1:0]     r_len;
  logic [DATA_W-1:0]     r_cnt;

  logic                  w_any;
  logic                  w_win;
  logic [DATA_W-1:0]     w_win_len;
  logic                  w_win_last;
  logic                  w_len_zero;
  logic [DATA_W:0]       w_len_p1;
  logic [DATA_W-1:0]     w_cnt_load;
  logic                  w_valid_g;
  logic [C_PCI_DATA_WIDTH-1:0] w_data_g;
  logic                  w_beat;
  logic                  w_last_beat;
  logic [1:0]            w_onehot;

  // Arbitration: on contention the pointer wins, otherwise the lone requester.
  assign w_any      = |REQ;
  assign w_win      = (&REQ) ? r_ptr : REQ[1];
  assign w_win_len  = w_win ? REQ_LEN[2*DATA_W-1:DATA_W] : REQ_LEN[DATA_W-1:0];
  assign w_win_last = w_win ? REQ_LAST[1] : REQ_LAST[0];

  // Beat count is (len+1)>>1 taken one bit wider so len = all-ones cannot wrap.
  assign w_len_zero = (r_len == '0);
  assign w_len_p1   = {1'b0, r_len} + {{DATA_W{1'b0}}, 1'b1};
  assign w_cnt_load = w_len_p1[DATA_W:1];

  assign w_valid_g   = r_idx ? REQ_DATA_VALID[1] : REQ_DATA_VALID[0];
  assign w_data_g    = r_idx ? REQ_DATA[2*C_PCI_DATA_WIDTH-1:C_PCI_DATA_WIDTH]
                             : REQ_DATA[C_PCI_DATA_WIDTH-1:0];
  assign w_beat      = (r_state == S_DATA) && w_valid_g && PCIE_CHNL_TX_DATA_REN;
  assign w_last_beat = w_beat && (r_cnt == {{(DATA_W-1){1'b0}}, 1'b1});
  assign w_onehot    = r_idx ? 2'b10 : 2'b01;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; a zero-length winner passes through REQ without TX to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_REQ;
      S_REQ: begin
        if (w_len_zero)            w_next = S_DONE;
        else if (PCIE_CHNL_TX_ACK) w_next = S_DATA;
      end
      S_DATA: if (w_last_beat) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction context: winner latch, round-robin pointer and beat down-counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr  <= 1'b0;
      r_idx  <= 1'b0;
      r_last <= 1'b0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_idx  <= w_win;
        r_ptr  <= ~w_win;
        r_len  <= w_win_len;
        r_last <= w_win_last;
      end
      if (r_state == S_REQ && !w_len_zero && PCIE_CHNL_TX_ACK) begin
        r_cnt <= w_cnt_load;
      end else if (w_beat) begin
        r_cnt <= r_cnt - {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs decoded from state; everything falls to zero with the async reset.
  always_comb begin
    PCIE_CHNL_TX            = 1'b0;
    GNT                     = 2'b00;
    DONE                    = 2'b00;
    REQ_DATA_REN            = 2'b00;
    PCIE_CHNL_TX_DATA_VALID = 1'b0;
    PCIE_CHNL_TX_DATA       = '0;
    BUSY                    = (r_state != S_IDLE);
    PCIE_CHNL_TX_LEN        = r_len;
    PCIE_CHNL_TX_LAST       = r_last;
    PCIE_CHNL_TX_OFF        = '0;
    case (r_state)
      S_REQ: begin
        PCIE_CHNL_TX = !w_len_zero;
        GNT          = w_onehot;
      end
      S_DATA: begin
        PCIE_CHNL_TX            = 1'b1;
        GNT                     = w_onehot;
        REQ_DATA_REN            = w_onehot & {2{PCIE_CHNL_TX_DATA_REN}};
        PCIE_CHNL_TX_DATA_VALID = w_valid_g;
        PCIE_CHNL_TX_DATA       = w_data_g;
      end
      S_DONE: DONE = w_onehot;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_pcie_tx_arb.sv
// Scoreboard bench for iob_pcie_tx_arb: stimulus pushes predicted transactions
// (round-robin order, beat count, data) into a queue; the monitor pops on DONE.
`timescale 1ns/1ps
module tb_iob_pcie_tx_arb;
  localparam int DW = 32;
  localparam int PW = 64;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [2*DW-1:0] req_len = '0;
  logic [1:0]      req_last = 2'b00;
  logic [2*PW-1:0] req_data = '0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ren;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic            busy;
  logic            tx;
  logic            ack = 1'b0;
  logic            tx_last;
  logic [DW-1:0]   tx_len;
  logic [DW-2:0]   tx_off;
  logic [PW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ren = 1'b0;

  iob_pcie_tx_arb #(.DATA_W(DW), .C_PCI_DATA_WIDTH(PW)) dut (
    .clk                     (clk),
    .arst_n                  (arst_n),
    .REQ                     (req),
    .REQ_LEN                 (req_len),
    .REQ_LAST                (req_last),
    .REQ_DATA                (req_data),
    .REQ_DATA_VALID          (req_valid),
    .REQ_DATA_REN            (req_ren),
    .GNT                     (gnt),
    .DONE                    (done),
    .BUSY                    (busy),
    .PCIE_CHNL_TX            (tx),
    .PCIE_CHNL_TX_ACK        (ack),
    .PCIE_CHNL_TX_LAST       (tx_last),
    .PCIE_CHNL_TX_LEN        (tx_len),
    .PCIE_CHNL_TX_OFF        (tx_off),
    .PCIE_CHNL_TX_DATA       (tx_data),
    .PCIE_CHNL_TX_DATA_VALID (tx_valid),
    .PCIE_CHNL_TX_DATA_REN   (tx_ren)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          len;
    bit          last;
    int          beats;
    logic [31:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] obs_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  bit          rnd_mode = 1'b0;
  int          ack_delay_cfg = 0;
  logic [31:0] tag [2];
  logic [31:0] bidx [2];
  logic [31:0] tag_ctr = 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_tx"},    64'(tx),       64'd0);
    chk({pfx, "_last"},  64'(tx_last),  64'd0);
    chk({pfx, "_len"},   64'(tx_len),   64'd0);
    chk({pfx, "_gnt"},   64'(gnt),      64'd0);
    chk({pfx, "_done"},  64'(done),     64'd0);
    chk({pfx, "_busy"},  64'(busy),     64'd0);
    chk({pfx, "_ren"},   64'(req_ren),  64'd0);
    chk({pfx, "_valid"}, 64'(tx_valid), 64'd0);
    chk({pfx, "_data"},  64'(tx_data),  64'd0);
    chk({pfx, "_off"},   64'(tx_off),   64'd0);
  endtask

  // Requesters and channel responder: drive at negedge, note accepted beats at +1.
  initial begin
    logic [1:0] pend;
    bit         acked;
    int         ack_cnt;
    pend = 2'b00; acked = 1'b0; ack_cnt = 0;
    tag[0] = '0; tag[1] = '0; bidx[0] = '0; bidx[1] = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        ack = 1'b0; tx_ren = 1'b0; req_valid = 2'b00; pend = 2'b00; acked = 1'b0;
        continue;
      end
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) bidx[i] = bidx[i] + 32'd1;
        if (gnt[i]) req[i] = 1'b0;
        req_data[i*PW +: PW] = {tag[i], bidx[i]};
        req_valid[i] = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      tx_ren = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!tx) begin
        acked   = 1'b0;
        ack_cnt = rnd_mode ? int'($urandom_range(0, 4)) : ack_delay_cfg;
        ack     = rnd_mode && ($urandom_range(0, 3) == 0);
      end else if (!acked) begin
        if (ack_cnt == 0) begin ack = 1'b1; acked = 1'b1; end
        else begin ack = 1'b0; ack_cnt--; end
      end else begin
        ack = rnd_mode && ($urandom_range(0, 3) == 0);
      end
      #1;
      for (int i = 0; i < 2; i++) pend[i] = req_ren[i] && req_valid[i];
    end
  end

  // Monitor: invariants every cycle, transaction check against the queue on DONE.
  initial begin
    int         cyc, gnt_cyc, tx_cyc;
    bit         in_txn, tx_seen;
    logic [1:0] prev_done;
    exp_t       e;
    cyc = 0; gnt_cyc = 0; tx_cyc = 0; in_txn = 1'b0; tx_seen = 1'b0; prev_done = 2'b00;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!arst_n) begin
        in_txn = 1'b0; tx_seen = 1'b0; prev_done = 2'b00; obs_q.delete();
        continue;
      end
      chk("off_zero", 64'(tx_off), 64'd0);
      chk("ren_not_granted", 64'(req_ren & ~gnt), 64'd0);
      if (gnt != 2'b00 || tx || done != 2'b00) chk("busy_active", 64'(busy), 64'd1);
      if (!tx) begin
        chk("valid_outside_data", 64'(tx_valid), 64'd0);
        chk("ren_outside_data", 64'(req_ren), 64'd0);
      end
      if (prev_done != 2'b00) chk("done_one_cycle", 64'(done), 64'd0);
      prev_done = done;
      if (gnt != 2'b00 && !in_txn) begin
        in_txn = 1'b1; tx_seen = 1'b0; gnt_cyc = cyc; obs_q.delete();
        if (exp_q.size() == 0) fail_now("unexpected_grant");
        else chk("grant_idx", 64'(gnt), 64'(2'b01 << exp_q[0].idx));
      end
      if (tx) begin
        if (!tx_seen) begin tx_seen = 1'b1; tx_cyc = cyc; end
        if (exp_q.size() != 0) begin
          chk("tx_len", 64'(tx_len), 64'(exp_q[0].len));
          chk("tx_last", 64'(tx_last), 64'(exp_q[0].last));
        end
      end
      if (tx_valid && tx_ren) begin
        obs_q.push_back(tx_data);
        chk("beat_ren", 64'(req_ren), 64'(gnt));
      end
      if (done != 2'b00) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("done_idx", 64'(done), 64'(2'b01 << e.idx));
          chk("beat_count", 64'(obs_q.size()), 64'(e.beats));
          for (int j = 0; j < obs_q.size() && j < e.beats; j++)
            chk("beat_data", obs_q[j], {e.tag, 32'(j)});
          chk("tx_asserted", 64'(tx_seen), 64'(e.len != 0));
          if (e.len == 0) chk("zero_len_done_latency", 64'(cyc - gnt_cyc), 64'd1);
          else            chk("tx_latency", 64'(tx_cyc - gnt_cyc), 64'd0);
        end
        in_txn = 1'b0; tx_seen = 1'b0; obs_q.delete();
      end
    end
  end

  task automatic run_round(input logic [1:0] mask, input int l0, input int l1,
                           input bit la0, input bit la1, input int ackd, input bit rnd);
    int         lens [2];
    bit         lasts [2];
    logic [1:0] pending;
    int         w;
    exp_t       e;
    int         c;
    lens[0] = l0; lens[1] = l1; lasts[0] = la0; lasts[1] = la1;
    @(negedge clk);
    #3;
    rnd_mode = rnd;
    ack_delay_cfg = ackd;
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        tag_ctr = tag_ctr + 32'd1;
        tag[i]  = tag_ctr;
        bidx[i] = '0;
        req_len[i*DW +: DW] = DW'(lens[i]);
        req_last[i] = lasts[i];
      end
    end
    pending = mask;
    while (pending != 2'b00) begin
      if (pending == 2'b11) w = m_ptr;
      else                  w = pending[1] ? 1 : 0;
      m_ptr   = 1 - w;
      e.idx   = w;
      e.len   = lens[w];
      e.last  = lasts[w];
      e.beats = (lens[w] + 1) / 2;
      e.tag   = tag[w];
      exp_q.push_back(e);
      pending[w] = 1'b0;
    end
    req = mask;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      fail_now("round_timeout");
      exp_q.delete();
      req = 2'b00;
    end
    @(negedge clk);
    #3;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_gnt", 64'(gnt), 64'd0);
  endtask

  initial begin
    int c;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    #3;
    arst_n = 1'b1;

    run_round(2'b01, 4, 0, 1'b1, 1'b0, 3, 1'b0);   // basic: 2 beats, ack after 3 cycles
    run_round(2'b11, 4, 6, 1'b0, 1'b1, 0, 1'b0);   // contention from reset
    run_round(2'b11, 2, 2, 1'b1, 1'b1, 1, 1'b0);   // contention again
    run_round(2'b01, 3, 0, 1'b0, 1'b0, 0, 1'b0);   // odd length rounds up
    run_round(2'b10, 0, 1, 1'b0, 1'b1, 2, 1'b0);   // single word
    run_round(2'b01, 0, 0, 1'b1, 1'b0, 0, 1'b0);   // zero length
    run_round(2'b11, 0, 5, 1'b0, 1'b0, 0, 1'b1);   // zero length under contention
    run_round(2'b10, 0, 8, 1'b0, 1'b1, 0, 1'b1);   // gaps on VALID and REN
    for (int r = 0; r < 25; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run_round(m, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 1'b1);
    end

    // Reset in the middle of a 4-beat transfer.
    @(negedge clk);
    #3;
    rnd_mode = 1'b0;
    ack_delay_cfg = 1;
    tag_ctr = tag_ctr + 32'd1;
    tag[0] = tag_ctr; bidx[0] = '0;
    req_len[DW-1:0] = DW'(8); req_last[0] = 1'b1;
    exp_q.push_back('{idx: 0, len: 8, last: 1'b1, beats: 4, tag: tag_ctr});
    m_ptr = 1;
    req = 2'b01;
    c = 0;
    while (obs_q.size() < 2 && c < 200) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (obs_q.size() < 2) fail_now("mid_reset_wait_timeout");
    arst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    req = 2'b00;
    exp_q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    #3;
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_round(2'b11, 2, 4, 1'b0, 1'b1, 0, 1'b0);   // pointer back to 0 after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
